cve2_sleep_ctrl: RTL and testbench
==================================

Name: cve2_sleep_ctrl

Overview:
Parametrised successor to the core-level main clock-gate enable logic. Latches fetch enable, tracks core busy, and ORs a configurable set of wake sources. An optional programmable idle hysteresis runs before the clock is gated. Drives the enable of the core clock gate and the sleep indication, and records wake cause and sleep statistics. Sits in the top level between the interrupt/debug inputs and the core clock gate.

Parameters:
NumWakeSrc, 4, number of extra maskable wake sources beyond debug/irq/nmi
IdleCntWidth, 8, width of idle hysteresis counter and idle_delay_i
SleepCntWidth, 16, width of saturating sleep-entry counter

Ports:
clk_i  in  1  free-running clock (ungated)
rst_i  in  1  synchronous reset, active-high
fetch_enable_i  in  1  fetch enable request (sticky once seen)
core_busy_i  in  1  core busy from core (unregistered)
debug_req_i  in  1  debug request, wake source
irq_pending_i  in  1  enabled interrupt pending, wake source
irq_nm_i  in  1  non-maskable interrupt, wake source
wake_src_i  in  NumWakeSrc  additional wake sources
wake_mask_i  in  NumWakeSrc  1 = corresponding wake_src_i enabled
idle_delay_i  in  IdleCntWidth  idle cycles before gating; 0 = legacy immediate gating
fetch_enable_o  out  1  registered sticky fetch enable to core
clock_en_o  out  1  enable for core clock gate
core_sleep_o  out  1  core is asleep
wake_cause_o  out  NumWakeSrc+3  {masked wake_src, nmi, irq, debug} captured at wakeup
sleep_cnt_o  out  SleepCntWidth  number of SLEEP entries, saturating

Behaviour:
- Reset (rst_i=1 at clk_i edge): state OFF; fetch_en_q=0, busy_q=0, idle cnt=0, wake_cause_o=0, sleep_cnt_o=0. Hence fetch_enable_o=0, clock_en_o=0, core_sleep_o=0. Reset mid-operation from any state is identical and takes priority over all events.
- fetch_en_q <= fetch_en_q | fetch_enable_i. Cleared only by reset. fetch_enable_o=fetch_en_q.
- busy_q <= core_busy_i every cycle.
- wake (comb) = debug_req_i | irq_pending_i | irq_nm_i | |(wake_src_i & wake_mask_i).
- FSM states OFF, RUN, IDLE_WAIT, SLEEP:
  - OFF: clock_en_o=0. Go to RUN when fetch_en_q=1, i.e. 2nd edge after fetch_enable_i rises.
  - RUN: clock_en_o = busy_q | wake | (idle_delay_i!=0).
    - If busy_q|wake: stay in RUN.
    - Else if idle_delay_i==0: go to SLEEP.
    - Else: cnt <= idle_delay_i-1 and go to IDLE_WAIT.
  - IDLE_WAIT: clock_en_o=1.
    - busy_q|wake: go to RUN (abort).
    - Else cnt==0: go to SLEEP.
    - Else cnt decrements.
    - idle_delay_i=N gives exactly N extra enabled cycles.
  - SLEEP: clock_en_o = busy_q | wake, combinational, for same-cycle wake. If busy_q|wake: go to RUN, and wake_cause_o <= {wake_src_i&wake_mask_i, irq_nm_i, irq_pending_i, debug_req_i}. Otherwise stay in SLEEP.
- core_sleep_o = fetch_en_q & ~clock_en_o. It is 0 in OFF because fetch_en_q=0 there.
- sleep_cnt_o increments on every transition into SLEEP and saturates at all-ones with no wrap.
- Simultaneous wake and idle expiry in IDLE_WAIT: wake wins, no SLEEP entry, counter unchanged.
- With idle_delay_i==0, clock_en_o/core_sleep_o equal the legacy function fetch_en_q & (busy_q|debug|irq|nmi) for all cycles after OFF.
- idle_delay_i is sampled only on the RUN to IDLE_WAIT transition. Changes during IDLE_WAIT have no effect.
- Masked wake_src_i bits never wake the core and never appear in wake_cause_o.

Test Plan:
- Reset, fetch_enable_i pulse 1 cycle at t0 -> fetch_enable_o=1 from t0+1, state RUN from t0+2; clock_en_o stays 0 before then and fetch_enable_o stays 1 after fetch_enable_i drops.
- idle_delay_i=0, core_busy_i drops at t1 with no wake -> clock_en_o=0 and core_sleep_o=1 from t1+1 (busy_q low); sleep_cnt_o=1.
- idle_delay_i=3, busy drops -> clock_en_o held 1 for busy_q-low cycle plus 3 IDLE_WAIT cycles, then 0; core_busy_i reasserted during IDLE_WAIT -> back to RUN, sleep_cnt_o unchanged.
- In SLEEP, wake_mask_i=4'b0010, wake_src_i=4'b0001 -> no wake; then wake_src_i=4'b0010 -> clock_en_o=1 same cycle, wake_cause_o=7'b0010000 next cycle, core_sleep_o=0.
- In SLEEP, irq_nm_i and debug_req_i together -> wake_cause_o=7'b0000101; assert rst_i in IDLE_WAIT -> all outputs 0 next edge, state OFF.
- SleepCntWidth=2, four sleep/wake cycles -> sleep_cnt_o sequence 1,2,3,3 (saturated).

Source files
------------

// File: rtl/cve2_sleep_ctrl.sv
// Core clock-gate enable and sleep controller: sticky fetch enable, maskable wake sources,
// optional idle hysteresis before gating, wake-cause capture and saturating sleep counter.
module cve2_sleep_ctrl #(
  parameter int unsigned NumWakeSrc    = 4,
  parameter int unsigned IdleCntWidth  = 8,
  parameter int unsigned SleepCntWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fetch_enable_i,
  input  logic                     core_busy_i,
  input  logic                     debug_req_i,
  input  logic                     irq_pending_i,
  input  logic                     irq_nm_i,
  input  logic [NumWakeSrc-1:0]    wake_src_i,
  input  logic [NumWakeSrc-1:0]    wake_mask_i,
  input  logic [IdleCntWidth-1:0]  idle_delay_i,
  output logic                     fetch_enable_o,
  output logic                     clock_en_o,
  output logic                     core_sleep_o,
  output logic [NumWakeSrc+2:0]    wake_cause_o,
  output logic [SleepCntWidth-1:0] sleep_cnt_o
);

  typedef enum logic [1:0] {
    StOff,
    StRun,
    StIdleWait,
    StSleep
  } state_e;

  state_e                   state_q;
  logic                     fetch_en_q;
  logic                     busy_q;
  logic [IdleCntWidth-1:0]  idle_cnt_q;
  logic [NumWakeSrc+2:0]    wake_cause_q;
  logic [SleepCntWidth-1:0] sleep_cnt_q;
  logic [SleepCntWidth-1:0] sleep_cnt_d;

  logic [NumWakeSrc-1:0] wake_src_masked;
  logic                  wake;
  logic                  active;
  logic                  idle_en;

  assign wake_src_masked = wake_src_i & wake_mask_i;
  assign wake            = debug_req_i | irq_pending_i | irq_nm_i | (|wake_src_masked);
  assign active          = busy_q | wake;
  assign idle_en         = (idle_delay_i != '0);
  assign sleep_cnt_d     = (sleep_cnt_q == '1) ? sleep_cnt_q
                                               : sleep_cnt_q + SleepCntWidth'(1);

  // Enable is combinational in SLEEP so a wake opens the gate in the same cycle.
  always_comb begin
    clock_en_o = 1'b0;
    case (state_q)
      StOff:      clock_en_o = 1'b0;
      StRun:      clock_en_o = active | idle_en;
      StIdleWait: clock_en_o = 1'b1;
      StSleep:    clock_en_o = active;
      default:    clock_en_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StOff;
      fetch_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      idle_cnt_q   <= '0;
      wake_cause_q <= '0;
      sleep_cnt_q  <= '0;
    end else begin
      fetch_en_q <= fetch_en_q | fetch_enable_i;
      busy_q     <= core_busy_i;
      case (state_q)
        StOff: begin
          if (fetch_en_q) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (!active) begin
            if (!idle_en) begin
              state_q     <= StSleep;
              sleep_cnt_q <= sleep_cnt_d;
            end else begin
              idle_cnt_q <= idle_delay_i - IdleCntWidth'(1);
              state_q    <= StIdleWait;
            end
          end
        end
        // A wake arriving on the expiry cycle aborts the sleep entry.
        StIdleWait: begin
          if (active) begin
            state_q <= StRun;
          end else if (idle_cnt_q == '0) begin
            state_q     <= StSleep;
            sleep_cnt_q <= sleep_cnt_d;
          end else begin
            idle_cnt_q <= idle_cnt_q - IdleCntWidth'(1);
          end
        end
        StSleep: begin
          if (active) begin
            state_q      <= StRun;
            wake_cause_q <= {wake_src_masked, irq_nm_i, irq_pending_i, debug_req_i};
          end
        end
        default: state_q <= StOff;
      endcase
    end
  end

  assign fetch_enable_o = fetch_en_q;
  assign core_sleep_o   = fetch_en_q & ~clock_en_o;
  assign wake_cause_o   = wake_cause_q;
  assign sleep_cnt_o    = sleep_cnt_q;

endmodule

// File: tb/tb_cve2_sleep_ctrl.sv
// Self-checking bench for cve2_sleep_ctrl: a default instance and a 2-bit sleep-counter instance
// share stimulus and are compared every cycle against a behavioural model of awake/idle/asleep.
module tb_cve2_sleep_ctrl;

  logic       clk;
  logic       rst;
  logic       fetchEnable;
  logic       coreBusy;
  logic       debugReq;
  logic       irqPending;
  logic       irqNm;
  logic [3:0] wakeSrc;
  logic [3:0] wakeMask;
  logic [7:0] idleDelay;

  logic        fetchEnOut, clockEnOut, coreSleepOut;
  logic [6:0]  wakeCauseOut;
  logic [15:0] sleepCntOut;
  logic        satFetchEnOut, satClockEnOut, satCoreSleepOut;
  logic [6:0]  satWakeCauseOut;
  logic [1:0]  satSleepCntOut;

  int errorCount = 0;
  int checkCount = 0;

  // Model state: started (left OFF), asleep, remaining hysteresis cycles (-1 = not idling).
  bit         mValid = 1'b0;
  bit         mFetchEn;
  bit         mBusyQ;
  bit         mStarted;
  bit         mAsleep;
  int         mIdleLeft;
  logic [6:0] mCause;
  int         mSleeps;

  cve2_sleep_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fetch_enable_i (fetchEnable),
    .core_busy_i    (coreBusy),
    .debug_req_i    (debugReq),
    .irq_pending_i  (irqPending),
    .irq_nm_i       (irqNm),
    .wake_src_i     (wakeSrc),
    .wake_mask_i    (wakeMask),
    .idle_delay_i   (idleDelay),
    .fetch_enable_o (fetchEnOut),
    .clock_en_o     (clockEnOut),
    .core_sleep_o   (coreSleepOut),
    .wake_cause_o   (wakeCauseOut),
    .sleep_cnt_o    (sleepCntOut)
  );

  cve2_sleep_ctrl #(.SleepCntWidth(2)) dutSat (
    .clk_i          (clk),
    .rst_i          (rst),
    .fetch_enable_i (fetchEnable),
    .core_busy_i    (coreBusy),
    .debug_req_i    (debugReq),
    .irq_pending_i  (irqPending),
    .irq_nm_i       (irqNm),
    .wake_src_i     (wakeSrc),
    .wake_mask_i    (wakeMask),
    .idle_delay_i   (idleDelay),
    .fetch_enable_o (satFetchEnOut),
    .clock_en_o     (satClockEnOut),
    .core_sleep_o   (satCoreSleepOut),
    .wake_cause_o   (satWakeCauseOut),
    .sleep_cnt_o    (satSleepCntOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic wakeNow();
    return debugReq | irqPending | irqNm | (|(wakeSrc & wakeMask));
  endfunction

  function automatic logic [6:0] causeNow();
    return {wakeSrc & wakeMask, irqNm, irqPending, debugReq};
  endfunction

  function automatic logic expClockEn();
    if (!mStarted) return 1'b0;
    if (mAsleep) return mBusyQ | wakeNow();
    if (mIdleLeft >= 0) return 1'b1;
    return mBusyQ | wakeNow() | (idleDelay != 8'd0);
  endfunction

  function automatic int satCount(input int value, input int limit);
    return (value > limit) ? limit : value;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mValid    <= 1'b1;
      mFetchEn  <= 1'b0;
      mBusyQ    <= 1'b0;
      mStarted  <= 1'b0;
      mAsleep   <= 1'b0;
      mIdleLeft <= -1;
      mCause    <= '0;
      mSleeps   <= 0;
    end else begin
      mFetchEn <= mFetchEn | fetchEnable;
      mBusyQ   <= coreBusy;
      if (!mStarted) begin
        mStarted <= mFetchEn;
      end else if (mAsleep) begin
        if (mBusyQ | wakeNow()) begin
          mAsleep <= 1'b0;
          mCause  <= causeNow();
        end
      end else if (mIdleLeft >= 0) begin
        if (mBusyQ | wakeNow()) begin
          mIdleLeft <= -1;
        end else if (mIdleLeft == 0) begin
          mIdleLeft <= -1;
          mAsleep   <= 1'b1;
          mSleeps   <= mSleeps + 1;
        end else begin
          mIdleLeft <= mIdleLeft - 1;
        end
      end else if (!(mBusyQ | wakeNow())) begin
        if (idleDelay == 8'd0) begin
          mAsleep <= 1'b1;
          mSleeps <= mSleeps + 1;
        end else begin
          mIdleLeft <= int'(idleDelay) - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("fetch_enable", 32'(fetchEnOut), 32'(mFetchEn));
      checkOutput("clock_en", 32'(clockEnOut), 32'(expClockEn()));
      checkOutput("core_sleep", 32'(coreSleepOut), 32'(mFetchEn & ~expClockEn()));
      checkOutput("wake_cause", 32'(wakeCauseOut), 32'(mCause));
      checkOutput("sleep_cnt", 32'(sleepCntOut), 32'(satCount(mSleeps, 65535)));
      checkOutput("sat_fetch_enable", 32'(satFetchEnOut), 32'(mFetchEn));
      checkOutput("sat_clock_en", 32'(satClockEnOut), 32'(expClockEn()));
      checkOutput("sat_core_sleep", 32'(satCoreSleepOut), 32'(mFetchEn & ~expClockEn()));
      checkOutput("sat_wake_cause", 32'(satWakeCauseOut), 32'(mCause));
      checkOutput("sat_sleep_cnt", 32'(satSleepCntOut), 32'(satCount(mSleeps, 3)));
    end
  end

  initial begin
    int satExp[4];
    satExp = '{1, 2, 3, 3};
    rst = 1'b1; fetchEnable = 1'b0; coreBusy = 1'b0; debugReq = 1'b0;
    irqPending = 1'b0; irqNm = 1'b0; wakeSrc = 4'b0; wakeMask = 4'b0; idleDelay = 8'd0;
    applyStimulus(2);
    checkOutput("lit_reset_fetch", 32'(fetchEnOut), 32'd0);
    checkOutput("lit_reset_clock_en", 32'(clockEnOut), 32'd0);
    checkOutput("lit_reset_sleep", 32'(coreSleepOut), 32'd0);
    checkOutput("lit_reset_cnt", 32'(sleepCntOut), 32'd0);

    // Start-up: one-cycle fetch pulse, RUN two edges later
    rst = 1'b0; fetchEnable = 1'b1; coreBusy = 1'b1;
    applyStimulus(1);
    fetchEnable = 1'b0;
    checkOutput("lit_fetch_t1", 32'(fetchEnOut), 32'd1);
    checkOutput("lit_clock_en_off", 32'(clockEnOut), 32'd0);
    applyStimulus(1);
    checkOutput("lit_clock_en_run", 32'(clockEnOut), 32'd1);
    checkOutput("lit_fetch_sticky", 32'(fetchEnOut), 32'd1);

    // Immediate gating with idle_delay 0
    coreBusy = 1'b0;
    applyStimulus(1);
    checkOutput("lit_legacy_gate", 32'(clockEnOut), 32'd0);
    checkOutput("lit_legacy_sleep", 32'(coreSleepOut), 32'd1);
    applyStimulus(1);
    checkOutput("lit_cnt_1", 32'(sleepCntOut), 32'd1);

    coreBusy = 1'b1;
    applyStimulus(2);

    // Hysteresis of 3: busy_q-low cycle plus 3 idle cycles stay enabled
    idleDelay = 8'd3; coreBusy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("lit_hyst_en", 32'(clockEnOut), 32'd1);
    end
    applyStimulus(1);
    checkOutput("lit_hyst_gated", 32'(clockEnOut), 32'd0);
    checkOutput("lit_cnt_2", 32'(sleepCntOut), 32'd2);

    // Abort in IDLE_WAIT by busy reassertion
    coreBusy = 1'b1;
    applyStimulus(2);
    coreBusy = 1'b0;
    applyStimulus(2);
    coreBusy = 1'b1;
    applyStimulus(3);
    checkOutput("lit_abort_cnt", 32'(sleepCntOut), 32'd2);

    // Enter SLEEP with delay 2, changing idle_delay mid-wait has no effect
    idleDelay = 8'd2; coreBusy = 1'b0;
    applyStimulus(2);
    idleDelay = 8'd0;
    applyStimulus(3);
    checkOutput("lit_cnt_3", 32'(sleepCntOut), 32'd3);

    // Masked wake source is ignored, enabled one wakes in the same cycle
    wakeMask = 4'b0010; wakeSrc = 4'b0001;
    #1;
    checkOutput("lit_masked_no_wake", 32'(clockEnOut), 32'd0);
    applyStimulus(1);
    checkOutput("lit_masked_still_sleep", 32'(coreSleepOut), 32'd1);
    wakeSrc = 4'b0010;
    #1;
    checkOutput("lit_src_wake_en", 32'(clockEnOut), 32'd1);
    checkOutput("lit_src_wake_sleep", 32'(coreSleepOut), 32'd0);
    applyStimulus(1);
    checkOutput("lit_cause_src", 32'(wakeCauseOut), 32'h10);
    wakeSrc = 4'b0000;
    applyStimulus(1);
    checkOutput("lit_cnt_4", 32'(sleepCntOut), 32'd4);

    // NMI and debug together
    irqNm = 1'b1; debugReq = 1'b1;
    applyStimulus(1);
    checkOutput("lit_cause_nmi_dbg", 32'(wakeCauseOut), 32'h05);
    irqNm = 1'b0; debugReq = 1'b0; idleDelay = 8'd3;
    applyStimulus(1);

    // Reset while in IDLE_WAIT
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("lit_rst_fetch", 32'(fetchEnOut), 32'd0);
    checkOutput("lit_rst_clock_en", 32'(clockEnOut), 32'd0);
    checkOutput("lit_rst_sleep", 32'(coreSleepOut), 32'd0);
    checkOutput("lit_rst_cause", 32'(wakeCauseOut), 32'd0);
    checkOutput("lit_rst_cnt", 32'(sleepCntOut), 32'd0);

    // Saturation of the 2-bit counter over four sleep/wake cycles
    rst = 1'b0; idleDelay = 8'd0; fetchEnable = 1'b1; coreBusy = 1'b1;
    applyStimulus(1);
    fetchEnable = 1'b0;
    applyStimulus(1);
    for (int k = 0; k < 4; k++) begin
      coreBusy = 1'b0;
      applyStimulus(2);
      checkOutput("lit_sat_cnt", 32'(satSleepCntOut), 32'(satExp[k]));
      checkOutput("lit_wide_cnt", 32'(sleepCntOut), 32'(k + 1));
      coreBusy = 1'b1;
      applyStimulus(2);
    end
    applyStimulus(2);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
